// File: rtl/vga_sync_detect.sv
// ---------------------------------------------------------------------------
// vga_sync_detect
//
// Receive side of a VGA timing link. Raw active-high h_sync/v_sync pulses are
// synchronized to the pixel clock and measured: clocks per line and lines per
// frame. Once the timing has proven stable, the block locks to it and
// regenerates video_on, pixel_x and pixel_y. These are the source's own signals
// delayed by exactly four clocks.
//
// Parameters
//   CNT_W      width of every counter and measured value (saturating)
//   H_DISPLAY  active pixels per line
//   H_BACK     clocks from h_sync falling edge to first active pixel
//   V_DISPLAY  active lines per frame
//   V_BACK     h_sync falling edges from v_sync falling edge to first active line
//   LOCK_LINES consecutive equal line periods required before locking
//
// Ports
//   clock      in   pixel clock
//   reset      in   asynchronous, active-high
//   h_sync_in  in   horizontal sync, asynchronous to clock, high = pulse
//   v_sync_in  in   vertical sync, asynchronous to clock, high = pulse
//   locked     out  timing stable; gates video_on
//   lock_lost  out  one-cycle pulse when a locked timing is abandoned
//   video_on   out  regenerated active-video flag
//   pixel_x    out  column in the active area, 0 outside it
//   pixel_y    out  row in the active area, 0 outside it
//   h_total    out  last measured clocks per line
//   v_total    out  last measured lines per frame
// ---------------------------------------------------------------------------
module vga_sync_detect #(
    parameter int CNT_W      = 11,
    parameter int H_DISPLAY  = 800,
    parameter int H_BACK     = 88,
    parameter int V_DISPLAY  = 600,
    parameter int V_BACK     = 23,
    parameter int LOCK_LINES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    output logic             locked,
    output logic             lock_lost,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total
);

    localparam int MATCH_W = $clog2(LOCK_LINES + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   X_START    = CNT_W'(H_BACK);
    localparam logic [CNT_W-1:0]   X_END      = CNT_W'(H_BACK + H_DISPLAY);
    localparam logic [CNT_W-1:0]   Y_START    = CNT_W'(V_BACK);
    localparam logic [CNT_W-1:0]   Y_END      = CNT_W'(V_BACK + V_DISPLAY);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_LINES);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_CONFIRM = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    logic               h_s1, h_s2, h_s2_d;
    logic               v_s1, v_s2, v_s2_d;
    logic               h_rise, h_fall, v_rise, v_fall;
    logic [CNT_W-1:0]   h_cnt, line_cnt, x_cnt, y_line, v_ref;
    logic [MATCH_W-1:0] h_match, h_match_next;
    logic               h_sat, line_sat;
    logic [CNT_W-1:0]   h_period, v_period;
    logic [1:0]         state, state_next;
    logic [CNT_W-1:0]   v_ref_next;
    logic               drop_lock;
    logic               in_x, in_y, video_next;

    // Two flops to resolve metastability, a third to give the previous level
    // for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_s1   <= 1'b0;
            h_s2   <= 1'b0;
            h_s2_d <= 1'b0;
            v_s1   <= 1'b0;
            v_s2   <= 1'b0;
            v_s2_d <= 1'b0;
        end else begin
            h_s1   <= h_sync_in;
            h_s2   <= h_s1;
            h_s2_d <= h_s2;
            v_s1   <= v_sync_in;
            v_s2   <= v_s1;
            v_s2_d <= v_s2;
        end
    end

    assign h_rise = h_s2 & ~h_s2_d;
    assign h_fall = ~h_s2 & h_s2_d;
    assign v_rise = v_s2 & ~v_s2_d;
    assign v_fall = ~v_s2 & v_s2_d;

    assign h_sat    = (h_cnt == CNT_MAX);
    assign line_sat = (line_cnt == CNT_MAX);

    // A saturated h_cnt means the line timed out; its period is pinned at the
    // maximum and never counts as a match.
    assign h_period = h_sat ? CNT_MAX : h_cnt + CNT_ONE;

    // When a line starts in the same cycle as the frame edge, that line
    // belongs to the frame that is ending.
    assign v_period = (h_rise && !line_sat) ? line_cnt + CNT_ONE : line_cnt;

    always_comb begin
        h_match_next = '0;
        if (!h_sat && (h_period == h_total)) begin
            h_match_next = (h_match == MATCH_FULL) ? h_match : h_match + MATCH_ONE;
        end
    end

    // Line/frame measurement and the position counters that video_on and
    // the pixel coordinates are derived from.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt    <= '0;
            h_total  <= '0;
            h_match  <= '0;
            line_cnt <= '0;
            v_total  <= '0;
            x_cnt    <= '0;
            y_line   <= '0;
        end else begin
            if (h_rise) begin
                h_cnt   <= '0;
                h_total <= h_period;
                h_match <= h_match_next;
            end else if (!h_sat) begin
                h_cnt <= h_cnt + CNT_ONE;
            end

            if (v_rise) begin
                line_cnt <= '0;
                v_total  <= v_period;
            end else if (h_rise && !line_sat) begin
                line_cnt <= line_cnt + CNT_ONE;
            end

            if (h_fall) begin
                x_cnt <= '0;
            end else if (x_cnt != CNT_MAX) begin
                x_cnt <= x_cnt + CNT_ONE;
            end

            if (v_fall) begin
                y_line <= '0;
            end else if (h_fall && (y_line != CNT_MAX)) begin
                y_line <= y_line + CNT_ONE;
            end
        end
    end

    // Lock state machine. The first frame edge only starts measuring (the
    // frame in progress is partial). Two equal full frames with settled line
    // periods are needed before locking. A line timeout forces a restart
    // from any state.
    always_comb begin
        state_next = state;
        v_ref_next = v_ref;
        case (state)
            ST_SEARCH: begin
                if (v_rise) state_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (v_rise) begin
                    state_next = ST_CONFIRM;
                    v_ref_next = v_period;
                end
            end
            ST_CONFIRM: begin
                if (v_rise) begin
                    if ((v_period == v_ref) && (v_period != '0) && (h_match == MATCH_FULL)) begin
                        state_next = ST_LOCKED;
                    end else begin
                        v_ref_next = v_period;
                    end
                end
            end
            ST_LOCKED: begin
                if ((h_rise && (h_period != h_total)) ||
                    (v_rise && (v_period != v_total)) ||
                    h_sat || line_sat) begin
                    state_next = ST_SEARCH;
                end
            end
            default: state_next = ST_SEARCH;
        endcase
        if (h_sat) state_next = ST_SEARCH;
    end

    assign drop_lock = (state == ST_LOCKED) && (state_next != ST_LOCKED);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_SEARCH;
            v_ref     <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_next;
            v_ref     <= v_ref_next;
            locked    <= (state_next == ST_LOCKED);
            lock_lost <= drop_lock;
        end
    end

    // The output stage uses the next lock state, not the current one.
    // This makes video_on fall in the same cycle that lock_lost pulses.
    assign in_x       = (x_cnt >= X_START) && (x_cnt < X_END);
    assign in_y       = (y_line >= Y_START) && (y_line < Y_END);
    assign video_next = (state_next == ST_LOCKED) && in_x && in_y;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            video_on <= 1'b0;
            pixel_x  <= '0;
            pixel_y  <= '0;
        end else begin
            video_on <= video_next;
            pixel_x  <= video_next ? x_cnt - X_START : '0;
            pixel_y  <= video_next ? y_line - Y_START : '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_detect.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_detect
//
// Drives vga_sync_detect from a behavioural sync generator. The generator has
// the same structure as 800x600 timing but is scaled down: 32 clocks/line,
// 14 lines/frame, 16x8 active area. This keeps each frame short while still
// using an 11-bit counter, so the saturation timeout stays at 2047.
// The generator's own video_on/pixel_x/pixel_y go into a scoreboard queue.
// They are compared with the DUT four clocks later.
// ---------------------------------------------------------------------------
module tb_vga_sync_detect;

    localparam int CNT_W  = 11;
    localparam int H_DISP = 16;
    localparam int H_SS   = 20;
    localparam int H_SE   = 24;
    localparam int H_TOT  = 32;
    localparam int V_DISP = 8;
    localparam int V_SS   = 9;
    localparam int V_SE   = 11;
    localparam int V_TOT  = 14;
    localparam int H_BACK = H_TOT - H_SE;
    localparam int V_BACK = V_TOT - V_SE;

    // The generator edge is seen after 2 synchronizer clocks.
    // The registered lock_lost pulse then adds 1 more clock.
    localparam int LOST_DELAY = 3;
    // The timeout pulse comes from the generator's last h_sync rise.
    // That rise takes 2 sync clocks, then 1 clock to clear h_cnt.
    // h_cnt then counts 2047 clocks, and the pulse is registered 1 clock later.
    localparam int SAT_DELAY = (1 << CNT_W) - 1 + 4;

    logic             clock, reset;
    logic             h_sync_in, v_sync_in;
    logic             locked, lock_lost, video_on;
    logic [CNT_W-1:0] pixel_x, pixel_y, h_total, v_total;

    vga_sync_detect #(
        .CNT_W     (CNT_W),
        .H_DISPLAY (H_DISP),
        .H_BACK    (H_BACK),
        .V_DISPLAY (V_DISP),
        .V_BACK    (V_BACK),
        .LOCK_LINES(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in),
        .locked   (locked),
        .lock_lost(lock_lost),
        .video_on (video_on),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .h_total  (h_total),
        .v_total  (v_total)
    );

    int checks = 0;
    int errors = 0;

    // generator state
    int  cyc = 0;
    bit  gen_run = 0, alt_mode = 0, align_mode = 0, long_line_req = 0, alt_phase = 0;
    int  hc = 0, vc = 0, line_len = H_TOT, frame_len = V_TOT;
    int  gen_hc_drv = -1, gen_vc_drv = -1;
    int  hr_cnt = 0, last_frame_lines = 0, gen_vrise_cnt = 0, last_hrise_cyc = 0;
    int  vline;
    bit  hs, vs, vid;
    logic [CNT_W-1:0] px, py;

    // scoreboard
    bit               sb_en = 0;
    logic [2*CNT_W:0] sb_q[$];
    logic [2*CNT_W:0] sb_exp;

    int ll_count = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Restart the generator at the top-left corner in the requested mode.
    task automatic applyStimulus(input bit alt, input bit align);
        alt_mode   = alt;
        align_mode = align;
        hc         = 0;
        vc         = 0;
        alt_phase  = 0;
        line_len   = H_TOT;
        frame_len  = V_TOT;
        hr_cnt     = 0;
        gen_run    = 1;
    endtask

    // The generator drives its outputs 1 time unit after each rising edge.
    // It also models how many lines each frame holds.
    initial begin
        h_sync_in = 1'b0;
        v_sync_in = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (gen_run) begin
                hs         = (hc >= H_SS) && (hc < H_SE);
                vline      = (align_mode && (hc < H_SS)) ? vc - 1 : vc;
                vs         = (vline >= V_SS) && (vline < V_SE);
                vid        = (hc < H_DISP) && (vc < V_DISP);
                gen_hc_drv = hc;
                gen_vc_drv = vc;
            end else begin
                hs         = 0;
                vs         = 0;
                vid        = 0;
                gen_hc_drv = -1;
                gen_vc_drv = -1;
            end
            if (hs && !h_sync_in) begin
                hr_cnt++;
                last_hrise_cyc = cyc;
            end
            if (vs && !v_sync_in) begin
                gen_vrise_cnt++;
                last_frame_lines = hr_cnt;
                hr_cnt = 0;
            end
            h_sync_in = hs;
            v_sync_in = vs;
            px = vid ? CNT_W'(hc) : {CNT_W{1'b0}};
            py = vid ? CNT_W'(vc) : {CNT_W{1'b0}};
            if (sb_en) sb_q.push_back({vid, px, py});
            if (gen_run) begin
                hc++;
                if (hc >= line_len) begin
                    hc            = 0;
                    line_len      = long_line_req ? H_TOT + 1 : H_TOT;
                    long_line_req = 0;
                    vc++;
                    if (vc >= frame_len) begin
                        vc        = 0;
                        alt_phase = ~alt_phase;
                        frame_len = (alt_mode && alt_phase) ? V_TOT - 1 : V_TOT;
                    end
                end
            end
        end
    end

    // Scoreboard consumer. An entry is popped once four newer ones exist.
    // That is exactly four clocks after the generator drove it.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            while (sb_q.size() > 4) begin
                sb_exp = sb_q.pop_front();
                checkOutput("video", {8'd0, video_on, pixel_x, pixel_y}, {8'd0, sb_exp});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (lock_lost === 1'b1) ll_count++;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic waitVrises(input string tag, input int n);
        int target = gen_vrise_cnt + n;
        int budget = (n + 1) * (H_TOT + 1) * V_TOT;
        while ((gen_vrise_cnt < target) && (budget > 0)) begin
            waitCycles(1);
            budget--;
        end
        checkOutput({tag, "_vrise_wait"}, 32'(gen_vrise_cnt >= target), 1);
    endtask

    task automatic waitGenPos(input string tag, input int h, input int v);
        int budget = 2 * H_TOT * V_TOT;
        while (!((gen_hc_drv == h) && (gen_vc_drv == v)) && (budget > 0)) begin
            waitCycles(1);
            budget--;
        end
        checkOutput({tag, "_pos_wait"}, 32'((gen_hc_drv == h) && (gen_vc_drv == v)), 1);
    endtask

    task automatic waitLockLost(input string tag, input int budget, output int delay);
        bit seen = 0;
        delay = -1;
        while (!seen && (budget > 0)) begin
            waitCycles(1);
            budget--;
            if (lock_lost === 1'b1) begin
                seen  = 1;
                delay = cyc - last_hrise_cyc;
            end
        end
        checkOutput({tag, "_seen"}, 32'(seen), 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_locked"},    32'(locked), 0);
        checkOutput({tag, "_lock_lost"}, 32'(lock_lost), 0);
        checkOutput({tag, "_video_on"},  32'(video_on), 0);
        checkOutput({tag, "_pixel_x"},   32'(pixel_x), 0);
        checkOutput({tag, "_pixel_y"},   32'(pixel_y), 0);
        checkOutput({tag, "_h_total"},   32'(h_total), 0);
        checkOutput({tag, "_v_total"},   32'(v_total), 0);
    endtask

    initial begin
        int delay;
        int ll_before;
        logic [CNT_W-1:0] prev_vt;

        reset = 1'b1;
        #12;
        $display("[TB] reset state");
        checkAllZero("rst");
        waitCycles(3);
        reset = 1'b0;

        $display("[TB] lock on nominal timing and compare video against generator");
        applyStimulus(0, 0);
        waitVrises("t1a", 2);
        waitCycles(5);
        checkOutput("t1_locked_after_2", 32'(locked), 0);
        waitVrises("t1b", 1);
        waitCycles(5);
        checkOutput("t1_locked_after_3", 32'(locked), 1);
        checkOutput("t1_h_total", 32'(h_total), H_TOT);
        checkOutput("t1_v_total", 32'(v_total), V_TOT);
        sb_en = 1;
        waitCycles(2 * H_TOT * V_TOT);
        sb_en = 0;
        waitCycles(6);
        sb_q.delete();
        checkOutput("t1_no_lock_lost", 32'(ll_count), 0);

        $display("[TB] single long line drops lock");
        long_line_req = 1;
        waitLockLost("t3_lost", 3 * H_TOT, delay);
        checkOutput("t3_lost_delay", 32'(delay), LOST_DELAY);
        checkOutput("t3_locked", 32'(locked), 0);
        checkOutput("t3_video_on", 32'(video_on), 0);
        waitVrises("t3", 3);
        waitCycles(5);
        checkOutput("t3_relocked", 32'(locked), 1);
        checkOutput("t3_h_total", 32'(h_total), H_TOT);

        $display("[TB] asynchronous reset while locked");
        waitGenPos("t5", 5, 3);
        waitCycles(4);
        checkOutput("t5_pre_video_on", 32'(video_on), 1);
        checkOutput("t5_pre_pixel_x", 32'(pixel_x), 5);
        checkOutput("t5_pre_pixel_y", 32'(pixel_y), 3);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("t5_rst");
        @(posedge clock);
        #2;
        waitCycles(2);
        reset = 1'b0;
        waitVrises("t5a", 2);
        waitCycles(5);
        checkOutput("t5_locked_after_2", 32'(locked), 0);
        waitVrises("t5b", 1);
        waitCycles(5);
        checkOutput("t5_locked_after_3", 32'(locked), 1);
        checkOutput("t5_v_total", 32'(v_total), V_TOT);

        $display("[TB] sync inputs held low while locked");
        waitGenPos("t2", 0, 0);
        gen_run = 0;
        ll_before = ll_count;
        waitLockLost("t2_lost", SAT_DELAY + 50, delay);
        checkOutput("t2_lost_delay", 32'(delay), SAT_DELAY);
        checkOutput("t2_locked", 32'(locked), 0);
        checkOutput("t2_video_on", 32'(video_on), 0);
        checkOutput("t2_pixel_x", 32'(pixel_x), 0);
        waitCycles(20);
        checkOutput("t2_single_pulse", 32'(ll_count - ll_before), 1);

        $display("[TB] alternating frame lengths never lock");
        applyStimulus(1, 0);
        prev_vt = '0;
        for (int f = 0; f < 7; f++) begin
            waitVrises("t4", 1);
            waitCycles(5);
            checkOutput("t4_locked", 32'(locked), 0);
            if (f >= 1) begin
                checkOutput("t4_v_total", 32'(v_total), 32'(last_frame_lines));
            end
            if (f >= 2) begin
                checkOutput("t4_v_toggle", 32'(v_total != prev_vt), 1);
            end
            prev_vt = v_total;
        end

        $display("[TB] v_sync rising together with h_sync");
        reset = 1'b1;
        applyStimulus(0, 1);
        waitCycles(2);
        reset = 1'b0;
        waitVrises("t6a", 3);
        waitCycles(5);
        checkOutput("t6_locked", 32'(locked), 1);
        checkOutput("t6_v_total", 32'(v_total), V_TOT);
        checkOutput("t6_h_total", 32'(h_total), H_TOT);
        ll_before = ll_count;
        waitVrises("t6b", 3);
        waitCycles(5);
        checkOutput("t6_still_locked", 32'(locked), 1);
        checkOutput("t6_v_total_hold", 32'(v_total), V_TOT);
        checkOutput("t6_no_lock_lost", 32'(ll_count - ll_before), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
